// File: rtl/framebuffer_arbiter.sv
// -----------------------------------------------------------------------------
// framebuffer_arbiter
//
// Shares one single-port 320x240x12 frame-buffer RAM between the VGA scan-out
// reader and the camera capture writer. Reads always win the RAM port; camera
// pixels wait in a small FIFO and drain into cycles the reader leaves free.
// A capture FSM sequences whole-frame writes and raises ready_display once a
// complete frame is stored.
//
// Optional build macro:
//   FB_WRITE_STARVE_GUARD_EN - after STARVE_LIMIT consecutive cycles with the
//   FIFO full and a read pending, the writer takes the RAM for one cycle.
//
// Ports:
//   sys_clk          clock
//   reset            asynchronous, active-low reset
//   capture_enable   level, 1 = capture frames
//   cam_frame_start  camera start-of-frame pulse
//   cam_wr_valid     camera pixel valid
//   cam_wr_data      camera pixel (RGB444)
//   cam_wr_ready     FIFO can accept a pixel
//   rd_req, rd_addr  VGA read request / address
//   rd_grant         read issued to the RAM this cycle
//   rd_data          read data (pass-through of ram_rdata)
//   rd_data_valid    rd_data valid (rd_grant delayed one cycle)
//   ram_addr, ram_wdata, ram_we, ram_rdata   RAM port, 1-cycle read latency
//   ready_display    a complete frame is present in RAM
//   short_frame      one-cycle pulse when a frame is restarted early
//
// State table:
//   S_IDLE     | capture disabled, FIFO empty
//   S_WAIT_SOF | armed, waiting for camera start-of-frame
//   S_CAPTURE  | accepting pixels and writing them to wr_addr
//   S_DONE     | full frame stored, holds until capture_enable drops
// -----------------------------------------------------------------------------
module framebuffer_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 12,
  parameter int FRAME_PIXELS = 76800,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              capture_enable,
  input  logic              cam_frame_start,
  input  logic              cam_wr_valid,
  input  logic [DATA_W-1:0] cam_wr_data,
  output logic              cam_wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ready_display,
  output logic              short_frame
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_CAPTURE  = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              ready_q, ready_d;
  logic              short_q, short_d;
  logic              rdv_q;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_rd_ptr_q, fifo_wr_ptr_q;
  logic [PTR_W:0]    fifo_cnt_q;

  logic in_capture, fifo_full, fifo_empty;
  logic push, pop, flush, last_wr, force_wr, grant_int;

  assign in_capture = (state_q == S_CAPTURE);
  assign fifo_full  = (fifo_cnt_q == FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);

`ifdef FB_WRITE_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_q, starve_d;

  assign force_wr = (starve_q == STARVE_MAX) & fifo_full & rd_req &
                    in_capture & capture_enable;

  always_comb begin
    starve_d = '0;
    if (force_wr) begin
      starve_d = '0;
    end else if (fifo_full && rd_req) begin
      // Saturate so a blocked force (capture disabled) cannot wrap the count.
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  // Guard compiled out: reads always win (expression is constant 0).
  assign force_wr = (STARVE_LIMIT < 0);
`endif

  // Grant: reads first, then FIFO drain while capturing.
  assign grant_int = rd_req & ~force_wr;
  assign pop       = ~grant_int & in_capture & ~fifo_empty & capture_enable;
  assign push      = in_capture & cam_wr_valid & ~fifo_full;
  assign last_wr   = pop & (wr_addr_q == LAST_ADDR);

  // Combinational outputs are forced low while reset is held.
  assign rd_grant     = reset & grant_int;
  assign cam_wr_ready = reset & (~in_capture | ~fifo_full);
  assign ram_we       = pop;
  assign ram_addr     = pop ? wr_addr_q : rd_addr;
  assign ram_wdata    = fifo_mem_q[fifo_rd_ptr_q];
  assign rd_data      = ram_rdata;

  assign rd_data_valid = rdv_q;
  assign ready_display = ready_q;
  assign short_frame   = short_q;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    ready_d   = ready_q;
    short_d   = 1'b0;
    flush     = 1'b0;
    if (!capture_enable) begin
      state_d = S_IDLE;
      flush   = 1'b1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_SOF;
        S_WAIT_SOF: begin
          if (cam_frame_start) begin
            state_d   = S_CAPTURE;
            wr_addr_d = '0;
            flush     = 1'b1;
          end
        end
        S_CAPTURE: begin
          // The last-pixel write takes priority over a coincident frame start.
          if (last_wr) begin
            state_d = S_DONE;
            ready_d = 1'b1;
          end else if (cam_frame_start) begin
            wr_addr_d = '0;
            flush     = 1'b1;
            short_d   = 1'b1;
          end else if (pop) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      ready_q   <= 1'b0;
      short_q   <= 1'b0;
      rdv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      ready_q   <= ready_d;
      short_q   <= short_d;
      rdv_q     <= rd_grant;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      fifo_rd_ptr_q <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_cnt_q    <= '0;
    end else if (flush) begin
      fifo_rd_ptr_q <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      if (push) fifo_wr_ptr_q <= fifo_wr_ptr_q + PTR_W'(1);
      if (pop)  fifo_rd_ptr_q <= fifo_rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (PTR_W + 1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Pixel storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem_q[fifo_wr_ptr_q] <= cam_wr_data;
  end

endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Shares the single-port 320x240x12 frame-buffer RAM between two requesters: the camera capture path (writer) and the VGA scan-out path (reader).
- Reads always have priority. Camera pixels are buffered in a small FIFO and drained into free RAM cycles.
- A capture state machine sequences whole-frame writes.
- Asserts ready_display once a complete frame is stored.

Parameters:
- ADDR_W, 17, RAM address width.
- DATA_W, 12, pixel width (RGB444).
- FRAME_PIXELS, 76800, pixels per frame (320*240).
- FIFO_DEPTH, 4, write FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive full-FIFO cycles before a forced write (optional feature only).

Ports:
- sys_clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- capture_enable  in  1  level; 1 = capture frames.
- cam_frame_start  in  1  one-cycle pulse at camera start-of-frame.
- cam_wr_valid  in  1  pixel valid.
- cam_wr_data  in  DATA_W  pixel.
- cam_wr_ready  out  1  FIFO can accept a pixel.
- rd_req  in  1  VGA read request.
- rd_addr  in  ADDR_W  VGA read address.
- rd_grant  out  1  read issued this cycle.
- rd_data  out  DATA_W  read data (pass-through of ram_rdata).
- rd_data_valid  out  1  rd_data valid.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency.
- ready_display  out  1  complete frame present in RAM.
- short_frame  out  1  one-cycle pulse when a frame is aborted early.

Behaviour:
- Reset: all registered outputs 0; FSM=IDLE; FIFO empty; wr_addr=0.
- Reset mid-frame takes effect immediately; no RAM write is issued while reset is low.
- FSM states:
  - IDLE: if capture_enable=1, go to WAIT_SOF.
  - WAIT_SOF: on cam_frame_start, go to CAPTURE with wr_addr=0 and FIFO flushed.
  - CAPTURE: FIFO pops write to wr_addr, then wr_addr+1. The cycle that writes address FRAME_PIXELS-1 moves to DONE.
  - DONE: holds. Only capture_enable=0 moves to IDLE.
  - capture_enable=0 in any state: go to IDLE next cycle, flush FIFO, clear ready_display.
- FIFO push:
  - Push only in CAPTURE when cam_wr_valid & cam_wr_ready.
  - cam_wr_ready = !full in CAPTURE, and 1 in all other states; pixels accepted outside CAPTURE are discarded.
  - Simultaneous push and pop leaves the count unchanged.
  - When full, ready is low; the source must hold its data.
- Grant, decided combinationally each cycle:
  - If rd_req: rd_grant=1, ram_addr=rd_addr, ram_we=0.
  - Else if FIFO non-empty and state=CAPTURE: pop, ram_we=1, ram_addr=wr_addr, ram_wdata=FIFO head.
  - Else: ram_we=0, ram_addr=rd_addr.
- Read latency: rd_data_valid is rd_grant registered by 1 cycle. rd_data = ram_rdata combinationally.
- Address width: wr_addr is ADDR_W bits and never exceeds FRAME_PIXELS-1. There is no wrap back to 0 inside CAPTURE.
- ready_display:
  - Registered; set the cycle after the last-pixel write.
  - Cleared only by reset or capture_enable=0.
  - A new frame is not captured while ready_display=1.
- Frame restart: cam_frame_start in CAPTURE before the last pixel causes, on the next cycle:
  - short_frame pulses 1 for one cycle;
  - FIFO is flushed;
  - wr_addr=0;
  - state stays CAPTURE.
- Frame-start priority: cam_frame_start in the same cycle as the last-pixel write is ignored; DONE wins and short_frame stays 0.
- Start-of-frame and pixels: cam_frame_start and a pixel push in the same cycle in WAIT_SOF: the FSM enters CAPTURE and the pixel is dropped.

Optional Feature:
- Macro: FB_WRITE_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the FIFO is full and rd_req=1, and resets otherwise.
  - At STARVE_LIMIT the write wins one cycle: rd_grant=0 despite rd_req, a pop occurs, and the counter clears.
  - The missed read produces no rd_data_valid 1 cycle later.
- Undefined: reads always win; a writer can stall indefinitely; the counter logic is absent.

Test Plan:
- Reset with capture_enable=1, cam_frame_start pulse, then 76800 valid pixels with rd_req=0 -> each pixel written at address 0..76799 in order; ready_display=1 the cycle after address 76799 is written; state DONE.
- rd_req held 1 with FIFO filling -> cam_wr_ready drops after 4 accepted pixels; no ram_we; rd_data_valid follows rd_grant by 1 cycle. Release rd_req -> 4 consecutive writes.
- cam_frame_start after 1000 pixels -> short_frame single-cycle pulse; next pixel written at address 0; ready_display stays 0.
- capture_enable dropped mid-CAPTURE with FIFO holding 3 entries -> IDLE next cycle; FIFO empty; no further ram_we; ready_display=0.
- reset asserted mid-frame -> all outputs 0 asynchronously; after release the FSM waits in WAIT_SOF and ignores pixels until cam_frame_start.
- With FB_WRITE_STARVE_GUARD_EN: FIFO full and rd_req=1 for 8 cycles -> ninth cycle has rd_grant=0 and ram_we=1; rd_data_valid low the following cycle.
